// File: rtl/palette_arbiter.sv
// palette_arbiter
// Shares a single-port palette RAM between the display read path (fixed
// latency, never stalled) and a host read/write port. The host is only
// granted cycles the display leaves free. Every RAM access pushes an owner
// tag into a shift register; when the tag reaches the tail, the RAM data is
// routed to the owner.
module palette_arbiter #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 24,
  parameter int RAM_LATENCY     = 2,
  parameter bit HOST_IN_VISIBLE = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              visible_region,
  input  logic              pix_valid,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_data_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  // One slot for the ram_addr register plus one per RAM pipeline stage.
  localparam int DEPTH = 1 + RAM_LATENCY;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_COOLDOWN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

  state_t state_r;
  state_t state_next_s;
  tag_t   tag_r [DEPTH];
  tag_t   tag_in_s;
  tag_t   tail_s;
  logic   grant_s;
  logic   host_wr_s;
  logic   host_rd_s;

  assign tail_s = tag_r[DEPTH-1];

  // Grant decision, owner tag for this cycle's access, and host FSM next state.
  always_comb begin
    grant_s      = 1'b0;
    host_wr_s    = 1'b0;
    host_rd_s    = 1'b0;
    tag_in_s     = TAG_NONE;
    state_next_s = state_r;

    // The display always wins; the host only gets free IDLE cycles.
    if (state_r == ST_IDLE) begin
      grant_s = host_req && !pix_valid && (HOST_IN_VISIBLE || !visible_region);
    end else begin
      grant_s = 1'b0;
    end
    host_wr_s = grant_s && host_we;
    host_rd_s = grant_s && !host_we;

    if (host_rd_s) begin
      tag_in_s = TAG_HOST;
    end else if (pix_valid) begin
      tag_in_s = TAG_DISP;
    end else begin
      tag_in_s = TAG_NONE;
    end

    case (state_r)
      ST_IDLE: begin
        if (host_wr_s) begin
          state_next_s = ST_WRITE;
        end else if (host_rd_s) begin
          state_next_s = ST_READ_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITE: state_next_s = ST_COOLDOWN;
      // host_ack is already high in this cycle, so the read is finished.
      ST_READ_WAIT: begin
        if (host_ack) begin
          state_next_s = ST_COOLDOWN;
        end else begin
          state_next_s = ST_READ_WAIT;
        end
      end
      ST_COOLDOWN: state_next_s = ST_IDLE;
      default:     state_next_s = ST_IDLE;
    endcase
  end

  // Host FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Owner tag pipeline; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i] <= TAG_NONE;
      end
    end else begin
      tag_r[0] <= tag_in_s;
      for (int i = 1; i < DEPTH; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // RAM command register: a host grant or a display read, otherwise idle with the address held.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= {DATA_W{1'b0}};
      ram_we    <= 1'b0;
    end else if (grant_s) begin
      ram_addr  <= host_addr;
      ram_wdata <= host_wdata;
      ram_we    <= host_we;
    end else if (pix_valid) begin
      ram_addr  <= pix_addr;
      ram_wdata <= ram_wdata;
      ram_we    <= 1'b0;
    end else begin
      ram_addr  <= ram_addr;
      ram_wdata <= ram_wdata;
      ram_we    <= 1'b0;
    end
  end

  // Deliver RAM data to the owner named by the tail tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_data       <= {DATA_W{1'b0}};
      pix_data_valid <= 1'b0;
      host_rdata     <= {DATA_W{1'b0}};
      host_ack       <= 1'b0;
    end else begin
      pix_data_valid <= (tail_s == TAG_DISP);
      host_ack       <= host_wr_s || (tail_s == TAG_HOST);
      if (tail_s == TAG_DISP) begin
        pix_data <= ram_q;
      end else begin
        pix_data <= pix_data;
      end
      if (tail_s == TAG_HOST) begin
        host_rdata <= ram_q;
      end else begin
        host_rdata <= host_rdata;
      end
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter with a 2-cycle palette RAM model.
module tb_palette_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        visible_region = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_addr = 8'h00;
  logic [23:0] pix_data;
  logic        pix_data_valid;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = 8'h00;
  logic [23:0] host_wdata = 24'h000000;
  logic        host_ack;
  logic [23:0] host_rdata;
  logic [7:0]  ram_addr;
  logic [23:0] ram_wdata;
  logic        ram_we;
  logic [23:0] ram_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic        hist_pv   [0:4095];
  logic [7:0]  hist_addr [0:4095];

  logic [23:0] mem [0:255];
  logic        mem_ready = 1'b0;
  logic [23:0] q_pipe [0:1];

  palette_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .visible_region (visible_region),
    .pix_valid      (pix_valid),
    .pix_addr       (pix_addr),
    .pix_data       (pix_data),
    .pix_data_valid (pix_data_valid),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ack       (host_ack),
    .host_rdata     (host_rdata),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_q          (ram_q)
  );

  always #5 clock = ~clock;

  // Palette RAM model: address registered at the RAM, data two cycles later.
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) begin
        mem[a] <= exp_pix(8'(a));
      end
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    q_pipe[0] <= mem[ram_addr];
    q_pipe[1] <= q_pipe[0];
  end
  assign ram_q = q_pipe[1];

  function automatic logic [23:0] exp_pix(input logic [7:0] a);
    return {a, a, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; records the display request seen at the edge and checks the
  // display output due from the request three edges earlier.
  task automatic step();
    int n;
    int k;
    @(posedge clock);
    n = cyc;
    hist_pv[n % 4096]   = pix_valid & ~reset;
    hist_addr[n % 4096] = pix_addr;
    cyc++;
    #1;
    if (n >= 3) begin
      k = (n - 3) % 4096;
      check("pix_data_valid", 32'(pix_data_valid), 32'(hist_pv[k]));
      if (hist_pv[k]) begin
        check("pix_data", 32'(pix_data), 32'(exp_pix(hist_addr[k])));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_data"},   32'(pix_data), 32'd0);
    check({tag, "_pix_valid"},  32'(pix_data_valid), 32'd0);
    check({tag, "_host_ack"},   32'(host_ack), 32'd0);
    check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_ram_addr"},   32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"},  32'(ram_wdata), 32'd0);
    check({tag, "_ram_we"},     32'(ram_we), 32'd0);
  endtask

  initial begin
    // Reset, then idle.
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_all_zero("rst");

    // Continuous display stream, addresses wrapping through the palette.
    visible_region = 1'b1;
    for (int c = 0; c < 644; c++) begin
      pix_valid = (c < 640);
      pix_addr  = c[7:0];
      step();
    end
    pix_valid      = 1'b0;
    visible_region = 1'b0;
    step();

    // Host write of 0x12, then read it back.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h12; host_wdata = 24'hA1B2C3;
    step();
    check("wr_ram_we",    32'(ram_we), 32'd1);
    check("wr_ack",       32'(host_ack), 32'd1);
    check("wr_ram_addr",  32'(ram_addr), 32'h12);
    check("wr_ram_wdata", 32'(ram_wdata), 32'hA1B2C3);
    host_req = 1'b0;
    step();
    check("wr_ack_cool", 32'(host_ack), 32'd0);
    check("wr_we_cool",  32'(ram_we), 32'd0);
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12; host_wdata = 24'h5A5A5A;
    step();
    check("rd_ram_addr", 32'(ram_addr), 32'h12);
    check("rd_ram_we",   32'(ram_we), 32'd0);
    check("rd_ack_g0",   32'(host_ack), 32'd0);
    host_addr = 8'h00; host_we = 1'b1;
    step();
    check("rd_ack_g1",    32'(host_ack), 32'd0);
    check("rd_stable_we", 32'(ram_we), 32'd0);
    step();
    check("rd_ack_g2", 32'(host_ack), 32'd0);
    step();
    check("rd_ack_g3", 32'(host_ack), 32'd1);
    check("rd_rdata",  32'(host_rdata), 32'hA1B2C3);
    host_req = 1'b0;
    step();
    check("rd_ack_cool", 32'(host_ack), 32'd0);
    check("rd_we_cool",  32'(ram_we), 32'd0);
    step();

    // Back-to-back writes with req held: grants exactly three cycles apart.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 24'h111111;
    step();
    check("b2b_ack0", 32'(host_ack), 32'd1);
    step();
    check("b2b_ack1", 32'(host_ack), 32'd0);
    check("b2b_we1",  32'(ram_we), 32'd0);
    step();
    check("b2b_ack2", 32'(host_ack), 32'd0);
    check("b2b_we2",  32'(ram_we), 32'd0);
    step();
    check("b2b_ack3", 32'(host_ack), 32'd1);
    check("b2b_we3",  32'(ram_we), 32'd1);
    host_req = 1'b0;
    step();
    step();

    // Host held off through the visible line and while display is active.
    visible_region = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 24'h0F0F0F;
    for (int i = 0; i < 8; i++) begin
      pix_valid = (i % 2 == 0);
      pix_addr  = 8'(8'h90 + i);
      step();
      check("vis_no_ack", 32'(host_ack), 32'd0);
      check("vis_no_we",  32'(ram_we), 32'd0);
    end
    visible_region = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix_addr = 8'(8'h98 + i);
      step();
      check("blank_pix_no_ack", 32'(host_ack), 32'd0);
    end
    pix_valid = 1'b0;
    step();
    check("blank_grant_ack",  32'(host_ack), 32'd1);
    check("blank_grant_we",   32'(ram_we), 32'd1);
    check("blank_grant_addr", 32'(ram_addr), 32'h30);
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Host read followed by three display reads: no cross-delivery.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    step();
    host_req = 1'b0;
    pix_valid = 1'b1; pix_addr = 8'h81;
    step();
    pix_addr = 8'h82;
    step();
    pix_addr = 8'h83;
    step();
    check("mix_ack",   32'(host_ack), 32'd1);
    check("mix_rdata", 32'(host_rdata), 32'h404040);
    pix_valid = 1'b0;
    step();
    check("mix_ack_off",  32'(host_ack), 32'd0);
    check("mix_rdata_hold", 32'(host_rdata), 32'h404040);
    for (int i = 0; i < 4; i++) step();

    // Reset during READ_WAIT drops the read; a re-issued read completes.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
    step();
    check("rr_ram_addr", 32'(ram_addr), 32'h12);
    host_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_no_ack", 32'(host_ack), 32'd0);
    end
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    step();
    check("rr2_ack1", 32'(host_ack), 32'd0);
    step();
    check("rr2_ack2", 32'(host_ack), 32'd0);
    step();
    check("rr2_ack3",  32'(host_ack), 32'd1);
    check("rr2_rdata", 32'(host_rdata), 32'hA1B2C3);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
